fpga_bus_ctrl: RTL

FPGA_BUS_CTRL -- requirements
Module: fpga_bus_ctrl

---
 rtl/fpga_bus_pkg.sv | 10 +
 rtl/fpga_bus_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/fpga_bus_pkg.sv
// fpga_bus_pkg: shared FSM state type and counter width helpers for fpga_bus_ctrl
package fpga_bus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA, DONE} state_t;
  function automatic int beat_w(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
  function automatic int tmo_w(input int timeout);
    return timeout > 1 ? $clog2(timeout) : 1;
  endfunction
endpackage

// File: rtl/fpga_bus_ctrl.sv
// fpga_bus_ctrl: line request to multiplexed address/data memory bus controller
// upstream: req_* accepts a line read/write, rsp_* returns a one-cycle completion with data/error
// memory side: *_c_to_m drive address/write beats with phase qualifiers, *_m_to_c return read beats/response
module fpga_bus_ctrl
  import fpga_bus_pkg::*;
#(
  parameter int ADDRESS_DATA_WIDTH = 32,
  parameter int BEATS = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [ADDRESS_DATA_WIDTH-1:0]       req_addr,
  input  logic [BEATS*ADDRESS_DATA_WIDTH-1:0] req_wdata,
  output logic                                rsp_valid,
  output logic [BEATS*ADDRESS_DATA_WIDTH-1:0] rsp_rdata,
  output logic                                rsp_error,
  output logic [ADDRESS_DATA_WIDTH-1:0]       address_data_bus_c_to_m,
  output logic                                address_on_c_to_m,
  output logic                                data_on_c_to_m,
  output logic                                read_en_c_to_m,
  output logic                                write_en_c_to_m,
  input  logic [ADDRESS_DATA_WIDTH-1:0]       address_data_bus_m_to_c,
  input  logic                                resp_m_to_c
);
  localparam int W = ADDRESS_DATA_WIDTH;
  localparam int LW = BEATS * W;
  localparam int BW = beat_w(BEATS);
  localparam int TW = tmo_w(TIMEOUT);
  state_t state, nxt;
  logic [W-1:0] addr_q;
  logic [LW-1:0] wdata_q, rbuf, rbuf_d;
  logic write_q, err_q, last, tmo;
  logic [BW-1:0] beat;
  logic [TW-1:0] tcnt;
  assign last = beat == BW'(BEATS - 1);
  assign tmo = tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    rbuf_d = rbuf;
    case (state)
      IDLE:  nxt = req_valid ? ADDR : IDLE;
      ADDR:  nxt = write_q ? WDATA : RDATA;
      WDATA: nxt = last ? WRESP : WDATA;
      WRESP: nxt = (resp_m_to_c || tmo) ? DONE : WRESP;
      RDATA: begin
        if (resp_m_to_c) rbuf_d[beat*W +: W] = address_data_bus_m_to_c;
        nxt = ((resp_m_to_c && last) || (!resp_m_to_c && tmo)) ? DONE : RDATA;
      end
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = rst && state == IDLE;
    rsp_valid = state == DONE;
    rsp_error = state == DONE && err_q;
    address_on_c_to_m = state == ADDR;
    data_on_c_to_m = state == WDATA;
    read_en_c_to_m = (state == ADDR && !write_q) || state == RDATA;
    write_en_c_to_m = (state == ADDR && write_q) || state == WDATA;
    address_data_bus_c_to_m = state == ADDR ? addr_q : state == WDATA ? wdata_q[beat*W +: W] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q <= 1'b0;
      beat <= '0;
      tcnt <= '0;
      rbuf <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      rbuf <= rbuf_d;
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
        err_q <= 1'b0;
        if (!req_write) rbuf <= '0;
      end
      beat <= state == ADDR ? '0 : (state == WDATA || (state == RDATA && resp_m_to_c)) ? beat + 1'b1 : beat;
      tcnt <= (state == WRESP || (state == RDATA && !resp_m_to_c)) ? tcnt + 1'b1 : '0;
      if ((state == WRESP || state == RDATA) && !resp_m_to_c && tmo) err_q <= 1'b1;
      if (state == RDATA && nxt == DONE) rsp_rdata <= rbuf_d;
    end
  end
endmodule
